mem_port_arbiter: RTL and testbench

- Sits directly upstream of the storage controller. Arbitrates the vector core's instruction-fetch and data ports onto the controller's single memory_access/out_valid interface.
- Holds the address, write data and byte enables stable for the whole transaction.
- Completes writes by a fixed latency, because the controller gives no write acknowledge.
- Bounds external-flash reads with a timeout and aborts cleanly when programming mode is entered.

---
 rtl/mem_port_arbiter.sv | 106 ++++++++++
 tb/tb_mem_port_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter of instruction/data ports onto a single storage-controller access port.
module mem_port_arbiter #(
  parameter int          MEM_W      = 32,
  parameter logic [31:0] SRAM_LIMIT = 32'h0000_2000,
  parameter int          WR_LAT     = 2,
  parameter int          TIMEOUT    = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_req,
  input  logic [31:0]        instr_addr,
  output logic               instr_gnt,
  output logic               instr_rvalid,
  output logic [MEM_W-1:0]   instr_rdata,
  output logic               instr_err,
  input  logic               data_req,
  input  logic               data_we,
  input  logic [MEM_W/8-1:0] data_be,
  input  logic [31:0]        data_addr,
  input  logic [MEM_W-1:0]   data_wdata,
  output logic               data_gnt,
  output logic               data_rvalid,
  output logic [MEM_W-1:0]   data_rdata,
  output logic               data_err,
  input  logic               prog_mode,
  output logic               memory_access,
  output logic               memory_is_writing,
  output logic [31:0]        addr,
  output logic [MEM_W-1:0]   d_in,
  output logic [MEM_W/8-1:0] mem_be,
  input  logic [MEM_W-1:0]   d_out,
  input  logic               out_valid
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_RD, WAIT_WR, RESP, PROG} state_t;
  localparam logic [15:0] TO_MAX = 16'(TIMEOUT - 1);
  localparam logic [15:0] WR_MAX = 16'(WR_LAT - 1);
  state_t state, state_nx;
  logic owner_d, last_d, resp_err, grant, pick_d, bad_wr;
  logic [15:0] cnt;
  logic [MEM_W-1:0] resp_data;
  assign grant  = state == IDLE && !prog_mode && (instr_req || data_req);
  // last_d resets to 0, so the data port wins the first tie
  assign pick_d = data_req && (!instr_req || !last_d);
  assign bad_wr = pick_d && data_we && data_addr >= SRAM_LIMIT;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = prog_mode ? PROG : grant ? (bad_wr ? RESP : ISSUE) : IDLE;
      ISSUE:   state_nx = prog_mode ? RESP : memory_is_writing ? WAIT_WR : WAIT_RD;
      WAIT_RD: state_nx = (prog_mode || out_valid || cnt == TO_MAX) ? RESP : WAIT_RD;
      WAIT_WR: state_nx = (prog_mode || cnt == WR_MAX) ? RESP : WAIT_WR;
      RESP:    state_nx = prog_mode ? PROG : IDLE;
      PROG:    state_nx = prog_mode ? PROG : IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      owner_d           <= 1'b0;
      last_d            <= 1'b0;
      cnt               <= '0;
      resp_data         <= '0;
      resp_err          <= 1'b0;
      memory_is_writing <= 1'b0;
      addr              <= '0;
      d_in              <= '0;
      mem_be            <= '0;
    end else begin
      cnt <= (state == WAIT_RD || state == WAIT_WR)
             ? cnt + {15'd0, cnt != (state == WAIT_RD ? TO_MAX : WR_MAX)} : '0;
      if (grant) begin
        owner_d           <= pick_d;
        last_d            <= pick_d;
        memory_is_writing <= pick_d && data_we;
        addr              <= pick_d ? data_addr : instr_addr;
        d_in              <= (pick_d && data_we) ? data_wdata : '0;
        mem_be            <= pick_d ? data_be : '1;
        resp_data         <= '0;
        resp_err          <= bad_wr;
      end else if (state_nx == IDLE || state_nx == PROG) begin
        memory_is_writing <= 1'b0;
        addr              <= '0;
        d_in              <= '0;
        mem_be            <= '0;
      end
      // an abort by prog_mode takes priority over read data arriving in the same cycle
      if (state_nx == RESP && state != IDLE) begin
        resp_err  <= prog_mode || (state == WAIT_RD && !out_valid);
        resp_data <= (state == WAIT_RD && !prog_mode && out_valid) ? d_out : '0;
      end
    end
  always_comb begin
    instr_gnt     = rst && grant && !pick_d;
    data_gnt      = rst && grant && pick_d;
    memory_access = state == ISSUE;
    instr_rvalid  = state == RESP && !owner_d;
    data_rvalid   = state == RESP && owner_d;
    instr_rdata   = instr_rvalid ? resp_data : '0;
    data_rdata    = data_rvalid ? resp_data : '0;
    instr_err     = instr_rvalid && resp_err;
    data_err      = data_rvalid && resp_err;
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed table, corner-case sequences and random traffic against a transaction-timeline model.
module tb_mem_port_arbiter;
  localparam int TIMEOUT = 8;
  localparam int WR_LAT = 2;
  localparam logic [31:0] SRAM_LIMIT = 32'h0000_2000;
  logic clk = 0, rst = 0;
  logic instr_req, data_req, data_we, prog_mode, out_valid;
  logic [31:0] instr_addr, data_addr, data_wdata, d_out;
  logic [3:0] data_be;
  logic instr_gnt, instr_rvalid, instr_err, data_gnt, data_rvalid, data_err, memory_access, memory_is_writing;
  logic [31:0] instr_rdata, data_rdata, addr, d_in;
  logic [3:0] mem_be;
  always #5 clk = ~clk;
  mem_port_arbiter #(.MEM_W(32), .SRAM_LIMIT(SRAM_LIMIT), .WR_LAT(WR_LAT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .instr_req(instr_req), .instr_addr(instr_addr), .instr_gnt(instr_gnt), .instr_rvalid(instr_rvalid),
    .instr_rdata(instr_rdata), .instr_err(instr_err),
    .data_req(data_req), .data_we(data_we), .data_be(data_be), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_gnt(data_gnt), .data_rvalid(data_rvalid), .data_rdata(data_rdata), .data_err(data_err),
    .prog_mode(prog_mode), .memory_access(memory_access), .memory_is_writing(memory_is_writing),
    .addr(addr), .d_in(d_in), .mem_be(mem_be), .d_out(d_out), .out_valid(out_valid)
  );
  typedef struct packed {
    logic ireq; logic [31:0] iaddr; logic dreq, dwe; logic [3:0] dbe; logic [31:0] daddr, dwdata;
    logic prog, ov; logic [31:0] dout;
  } in_t;
  typedef struct packed {
    logic ig, dg, irv, drv, ierr, derr, macc, mwr; logic [31:0] irdata, drdata, addr, din; logic [3:0] be;
  } out_t;
  typedef struct { in_t i; out_t o; } vec_t;
  int n_vec = 0, n_bad = 0, ncyc = 0;
  // model: a transaction is described by its age in cycles since the grant
  bit m_busy, m_resp, m_prog, m_last_d, m_is_d, m_wr, m_rej, m_err;
  int m_age;
  logic [31:0] m_addr, m_din, m_rdata;
  logic [3:0] m_be;
  function automatic in_t mk_i(logic ireq, logic [31:0] iaddr, logic dreq, logic dwe, logic [3:0] dbe,
                               logic [31:0] daddr, logic [31:0] dwdata, logic prog, logic ov, logic [31:0] dout);
    in_t v;
    v.ireq = ireq; v.iaddr = iaddr; v.dreq = dreq; v.dwe = dwe; v.dbe = dbe; v.daddr = daddr;
    v.dwdata = dwdata; v.prog = prog; v.ov = ov; v.dout = dout;
    return v;
  endfunction
  function automatic out_t mk_o(logic ig, logic dg, logic irv, logic drv, logic err, logic macc, logic mwr,
                                logic [31:0] rdata, logic [31:0] a, logic [31:0] din, logic [3:0] be);
    out_t o;
    o.ig = ig; o.dg = dg; o.irv = irv; o.drv = drv; o.ierr = irv & err; o.derr = drv & err;
    o.macc = macc; o.mwr = mwr; o.irdata = irv ? rdata : 32'd0; o.drdata = drv ? rdata : 32'd0;
    o.addr = a; o.din = din; o.be = be;
    return o;
  endfunction
  function automatic out_t sample();
    out_t o;
    o.ig = instr_gnt; o.dg = data_gnt; o.irv = instr_rvalid; o.drv = data_rvalid; o.ierr = instr_err;
    o.derr = data_err; o.macc = memory_access; o.mwr = memory_is_writing; o.irdata = instr_rdata;
    o.drdata = data_rdata; o.addr = addr; o.din = d_in; o.be = mem_be;
    return o;
  endfunction
  task automatic apply(input in_t v);
    instr_req = v.ireq; instr_addr = v.iaddr; data_req = v.dreq; data_we = v.dwe; data_be = v.dbe;
    data_addr = v.daddr; data_wdata = v.dwdata; prog_mode = v.prog; out_valid = v.ov; d_out = v.dout;
  endtask
  task automatic m_reset();
    m_busy = 0; m_resp = 0; m_prog = 0; m_last_d = 0; m_is_d = 0; m_wr = 0; m_rej = 0; m_err = 0;
    m_age = 0; m_addr = 0; m_din = 0; m_rdata = 0; m_be = 0;
  endtask
  task automatic model_step(input in_t v, output out_t e);
    e = '0;
    if (m_busy) begin
      e.addr = m_addr; e.din = m_din; e.be = m_be; e.mwr = m_wr;
      e.macc = m_age == 1 && !m_rej;
      if (m_resp) begin
        if (m_is_d) begin e.drv = 1; e.derr = m_err; e.drdata = m_rdata; end
        else begin e.irv = 1; e.ierr = m_err; e.irdata = m_rdata; end
        m_busy = 0; m_resp = 0; m_prog = v.prog;
      end else begin
        if (v.prog) begin m_resp = 1; m_err = 1; m_rdata = 0; end
        else if (!m_wr && m_age >= 2 && v.ov) begin m_resp = 1; m_err = 0; m_rdata = v.dout; end
        else if (!m_wr && m_age == 1 + TIMEOUT) begin m_resp = 1; m_err = 1; m_rdata = 0; end
        else if (m_wr && m_age == 1 + WR_LAT) begin m_resp = 1; m_err = 0; m_rdata = 0; end
        m_age++;
      end
    end else if (m_prog) m_prog = v.prog;
    else if (v.prog) m_prog = 1;
    else if (v.ireq || v.dreq) begin
      m_is_d = v.dreq && (!v.ireq || !m_last_d);
      m_last_d = m_is_d;
      e.ig = !m_is_d; e.dg = m_is_d;
      m_wr = m_is_d && v.dwe;
      m_addr = m_is_d ? v.daddr : v.iaddr;
      m_be = m_is_d ? v.dbe : 4'hF;
      m_din = m_wr ? v.dwdata : 32'd0;
      m_rej = m_wr && m_addr >= SRAM_LIMIT;
      m_busy = 1; m_age = 1; m_resp = m_rej; m_err = m_rej; m_rdata = 0;
    end
  endtask
  task automatic cmp(input string nm, input out_t a, input out_t e);
    n_vec++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_vec++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask
  task automatic cyc(input in_t v, output out_t a);
    out_t e;
    @(negedge clk);
    apply(v);
    #1;
    a = sample();
    model_step(v, e);
    cmp($sformatf("model cyc %0d", ncyc), a, e);
    ncyc++;
  endtask
  function automatic logic [31:0] rnd_addr();
    int r;
    r = $urandom % 8;
    if (r == 0) return 32'h1FFF + 32'($urandom % 2);
    if (r < 4) return 32'($urandom_range(0, 32'h1FFF));
    return 32'h2000 + 32'($urandom_range(0, 32'hFFFF));
  endfunction
  vec_t tbl [14];
  initial begin
    in_t z, fl, v, rd, wr;
    out_t a, zo;
    logic [2:0] ord;
    int ng, n, got, nrv;
    bit pr;
    z = '0; zo = '0; fl = '0; fl.ov = 1;
    tbl[0]  = '{mk_i(0, 0, 1, 0, 4'hF, 32'h40, 0, 0, 0, 0), mk_o(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0)};
    tbl[1]  = '{z, mk_o(0, 0, 0, 0, 0, 1, 0, 0, 32'h40, 0, 4'hF)};
    tbl[2]  = '{mk_i(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF), mk_o(0, 0, 0, 0, 0, 0, 0, 0, 32'h40, 0, 4'hF)};
    tbl[3]  = '{z, mk_o(0, 0, 0, 1, 0, 0, 0, 32'hDEADBEEF, 32'h40, 0, 4'hF)};
    tbl[4]  = '{z, zo};
    tbl[5]  = '{mk_i(0, 0, 1, 1, 4'h3, 32'h100, 32'h12345678, 0, 0, 0), mk_o(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0)};
    tbl[6]  = '{z, mk_o(0, 0, 0, 0, 0, 1, 1, 0, 32'h100, 32'h12345678, 4'h3)};
    tbl[7]  = '{z, mk_o(0, 0, 0, 0, 0, 0, 1, 0, 32'h100, 32'h12345678, 4'h3)};
    tbl[8]  = '{mk_i(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hFFFFFFFF), mk_o(0, 0, 0, 0, 0, 0, 1, 0, 32'h100, 32'h12345678, 4'h3)};
    tbl[9]  = '{z, mk_o(0, 0, 0, 1, 0, 0, 1, 0, 32'h100, 32'h12345678, 4'h3)};
    tbl[10] = '{z, zo};
    tbl[11] = '{mk_i(0, 0, 1, 1, 4'hF, 32'h0010_0000, 32'hAA, 0, 0, 0), mk_o(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0)};
    tbl[12] = '{z, mk_o(0, 0, 0, 1, 1, 0, 1, 0, 32'h0010_0000, 32'hAA, 4'hF)};
    tbl[13] = '{z, zo};
    m_reset();
    apply(z);
    instr_req = 1; data_req = 1;
    repeat (2) @(negedge clk);
    #1 cmp("reset_state", sample(), zo);
    @(negedge clk);
    apply(z);
    rst = 1;
    // simultaneous requests held: data, instr, data
    v = z; v.ireq = 1; v.iaddr = 32'h100; v.dreq = 1; v.daddr = 32'h200; v.dbe = 4'hF; v.ov = 1;
    ord = 0; ng = 0;
    for (int k = 0; k < 30 && ng < 3; k++) begin
      v.dout = $urandom;
      cyc(v, a);
      if (a.ig || a.dg) begin ord[ng] = a.dg; ng++; end
    end
    chk("tie_count", ng, 3);
    chk("tie_order", 32'(ord), 32'b101);
    repeat (12) cyc(fl, a);
    for (int r = 0; r < 14; r++) begin
      cyc(tbl[r].i, a);
      cmp($sformatf("tbl row %0d", r), a, tbl[r].o);
    end
    // flash read timeout
    v = z; v.ireq = 1; v.iaddr = 32'h4000;
    cyc(v, a);
    chk("to_gnt", 32'(a.ig), 1);
    n = 0; got = 0;
    for (int k = 1; k < 40 && got == 0; k++) begin
      cyc(z, a);
      if (a.irv) begin
        got = 1; n = k;
        chk("to_err", 32'(a.ierr), 1);
        chk("to_rdata", a.irdata, 0);
      end
    end
    chk("to_rvalid_seen", got, 1);
    chk("to_wait_cycles", n - 2, TIMEOUT);
    v.iaddr = 32'h44;
    cyc(v, a);
    chk("to_next_gnt", 32'(a.ig), 1);
    repeat (12) cyc(fl, a);
    // programming mode abort during WAIT_RD
    rd = z; rd.dreq = 1; rd.daddr = 32'h80; rd.dbe = 4'hF;
    cyc(rd, a);
    chk("prog_gnt", 32'(a.dg), 1);
    cyc(z, a);
    cyc(z, a);
    v = z; v.prog = 1;
    cyc(v, a);
    v.dreq = 1; v.daddr = 32'h84;
    cyc(v, a);
    chk("prog_abort_rvalid", 32'(a.drv), 1);
    chk("prog_abort_err", 32'(a.derr), 1);
    repeat (3) begin
      cyc(v, a);
      chk("prog_no_gnt", 32'(a.dg | a.ig), 0);
    end
    v.prog = 0;
    cyc(v, a);
    chk("prog_exit_no_gnt", 32'(a.dg), 0);
    cyc(v, a);
    chk("prog_resume_gnt", 32'(a.dg), 1);
    repeat (12) cyc(fl, a);
    // async reset in WAIT_WR
    wr = z; wr.dreq = 1; wr.dwe = 1; wr.dbe = 4'hF; wr.daddr = 32'h100; wr.dwdata = 32'h55;
    cyc(wr, a);
    cyc(z, a);
    cyc(z, a);
    instr_req = 1; data_req = 1;
    #1 rst = 0;
    #1 cmp("async_reset", sample(), zo);
    @(negedge clk);
    apply(z);
    rst = 1;
    m_reset();
    nrv = 0;
    repeat (6) begin
      cyc(z, a);
      nrv += 32'(a.irv | a.drv);
    end
    chk("no_rvalid_after_reset", nrv, 0);
    pr = 0;
    for (int k = 0; k < 3000; k++) begin
      v.ireq = ($urandom % 3) == 0; v.iaddr = rnd_addr();
      v.dreq = ($urandom % 3) == 0; v.dwe = 1'($urandom % 2); v.dbe = 4'($urandom);
      v.daddr = rnd_addr(); v.dwdata = $urandom;
      v.ov = ($urandom % 4) == 0; v.dout = $urandom;
      if ($urandom % 50 == 0) pr = !pr;
      v.prog = pr;
      cyc(v, a);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
